// File: rtl/vram_arbiter_if.sv
// Host and RAM bus bundle for vram_arbiter.
// The host read port exists only when VRAM_HOST_READ_EN is defined.
interface vram_arbiter_if #(
  parameter int ADDR_W = 15
) ();
  logic              host_req;
  logic [ADDR_W-1:0] host_addr;
  logic [15:0]       host_wdata;
  logic              host_ack;
`ifdef VRAM_HOST_READ_EN
  logic              host_we;
  logic [15:0]       host_rdata;
  logic              host_rvalid;
`endif
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;

  // Arbiter side: serves the host, drives the RAM.
  modport slave (
    input  host_req, host_addr, host_wdata,
    output host_ack,
`ifdef VRAM_HOST_READ_EN
    input  host_we,
    output host_rdata, host_rvalid,
`endif
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  // Environment side: the host writer and the RAM itself.
  modport master (
    output host_req, host_addr, host_wdata,
    input  host_ack,
`ifdef VRAM_HOST_READ_EN
    output host_we,
    input  host_rdata, host_rvalid,
`endif
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares one single-port synchronous RAM between the 2x2-scaled
// 320x240x4bpp display fetch path and a host writer. Display reads use fixed
// slots derived from pixel_x/pixel_y; the host takes any other cycle, never
// two in a row. Define VRAM_HOST_READ_EN to add host reads.
module vram_arbiter #(
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int ADDR_W   = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [9:0]     pixel_x,
  input  logic [9:0]     pixel_y,
  output logic [3:0]     pix_color,
  output logic           pix_blank,
  vram_arbiter_if.slave  bus
);
  localparam int WPL      = H_ACTIVE / 8;
  localparam int FB_WORDS = (V_ACTIVE / 2) * WPL;

  localparam logic [9:0] H_ACT_C     = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_C     = 10'(V_ACTIVE);
  localparam logic [9:0] H_LAST_C    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST_C    = 10'(V_TOTAL - 1);
  localparam logic [9:0] LS_X_C      = 10'(H_TOTAL - 8);
  localparam logic [9:0] LAST_SLOT_C = 10'(8 * (WPL - 1) - 8);
  localparam logic [ADDR_W-1:0] WPL_A = ADDR_W'(WPL);
  localparam logic [ADDR_W-1:0] FB_A  = ADDR_W'(FB_WORDS);

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic              host_ack_q, host_ack_d;
  logic [3:0]        pix_color_q, pix_color_d;
  logic              pix_blank_q, pix_blank_d;
  logic [15:0]       cur_word_q, cur_word_d;
  logic [15:0]       next_word_q, next_word_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              fetch_p1_q, fetch_p1_d;
  logic              fetch_p2_q, fetch_p2_d;

  logic              active, grp_start, disp_slot, ls_slot, next_line_active;
  logic              fetch, grant, in_range, host_is_read;
  logic [ADDR_W-1:0] next_base, fetch_addr;
  logic [15:0]       word_sel;

`ifdef VRAM_HOST_READ_EN
  logic        rd_p1_q, rd_p1_d;
  logic        rd_oob_p1_q, rd_oob_p1_d;
  logic        rvalid_q, rvalid_d;
  logic        rvalid_oob_q, rvalid_oob_d;
  logic [15:0] rhold_q, rhold_d;
  logic [15:0] host_rdata_c;
  assign host_is_read = !bus.host_we;
`else
  assign host_is_read = 1'b0;
`endif

  // Slot decode and host arbitration for the current raster position.
  always_comb begin
    active           = (pixel_x < H_ACT_C) && (pixel_y < V_ACT_C);
    grp_start        = (pixel_x[2:0] == 3'd0);
    disp_slot        = (pixel_y < V_ACT_C) && grp_start && (pixel_x <= LAST_SLOT_C);
    ls_slot          = (pixel_x == LS_X_C);
    next_line_active = (pixel_y == V_LAST_C) || ((pixel_y + 10'd1) < V_ACT_C);
    // Base of the following line: bumps after odd active lines, wraps at frame end.
    if (pixel_y == V_LAST_C)
      next_base = '0;
    else if ((pixel_y < V_ACT_C) && pixel_y[0])
      next_base = base_q + WPL_A;
    else
      next_base = base_q;
    fetch      = disp_slot || (ls_slot && next_line_active);
    fetch_addr = disp_slot ? (base_q + ADDR_W'(pixel_x[9:3]) + ADDR_W'(1)) : next_base;
    grant      = bus.host_req && !disp_slot && !ls_slot && !host_ack_q;
    in_range   = (bus.host_addr < FB_A);
    // The word covering this group arrives in cur_word only at the edge, so bypass it.
    word_sel   = (active && grp_start) ? next_word_q : cur_word_q;
  end

  // Next-state for the RAM port, word buffers and pixel outputs.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    host_ack_d  = grant;
    fetch_p1_d  = fetch;
    fetch_p2_d  = fetch_p1_q;
    next_word_d = fetch_p2_q ? bus.mem_rdata : next_word_q;
    cur_word_d  = (active && grp_start) ? next_word_q : cur_word_q;
    base_d      = (pixel_x == H_LAST_C) ? next_base : base_q;
    pix_blank_d = !active;
    pix_color_d = active ? word_sel[{pixel_x[2:1], 2'b00} +: 4] : 4'd0;
    if (fetch) begin
      mem_addr_d = fetch_addr;
    end else if (grant && in_range) begin
      mem_addr_d = bus.host_addr;
      if (!host_is_read) begin
        mem_we_d    = 1'b1;
        mem_wdata_d = bus.host_wdata;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      host_ack_q  <= 1'b0;
      pix_color_q <= '0;
      pix_blank_q <= 1'b1;
      cur_word_q  <= '0;
      next_word_q <= '0;
      base_q      <= '0;
      fetch_p1_q  <= 1'b0;
      fetch_p2_q  <= 1'b0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      host_ack_q  <= host_ack_d;
      pix_color_q <= pix_color_d;
      pix_blank_q <= pix_blank_d;
      cur_word_q  <= cur_word_d;
      next_word_q <= next_word_d;
      base_q      <= base_d;
      fetch_p1_q  <= fetch_p1_d;
      fetch_p2_q  <= fetch_p2_d;
    end
  end

`ifdef VRAM_HOST_READ_EN
  // Host read return path: data shows up with host_rvalid and is then held.
  always_comb begin
    host_rdata_c = rvalid_q ? (rvalid_oob_q ? 16'd0 : bus.mem_rdata) : rhold_q;
    rd_p1_d      = grant && host_is_read;
    rd_oob_p1_d  = !in_range;
    rvalid_d     = rd_p1_q;
    rvalid_oob_d = rd_oob_p1_q;
    rhold_d      = host_rdata_c;
  end

  // Host read pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_p1_q      <= 1'b0;
      rd_oob_p1_q  <= 1'b0;
      rvalid_q     <= 1'b0;
      rvalid_oob_q <= 1'b0;
      rhold_q      <= '0;
    end else begin
      rd_p1_q      <= rd_p1_d;
      rd_oob_p1_q  <= rd_oob_p1_d;
      rvalid_q     <= rvalid_d;
      rvalid_oob_q <= rvalid_oob_d;
      rhold_q      <= rhold_d;
    end
  end

  assign bus.host_rdata  = host_rdata_c;
  assign bus.host_rvalid = rvalid_q;
`endif

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.host_ack  = host_ack_q;
  assign pix_color     = pix_color_q;
  assign pix_blank     = pix_blank_q;
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port synchronous video RAM between the display fetch path and a host writer (game logic).
- Framebuffer: 320x240, 4 bpp, 16-bit words, 4 pixels per word, nibble i = bits [4i+3:4i] with pixel 0 in the LSBs.
- Scaled 2x2 onto the 640x480 raster from the sync generator.
- Display reads use fixed, deterministic slots tied to pixel_x/pixel_y. The host gets every other memory cycle.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- H_TOTAL, 800, pixels per line including blanking.
- V_ACTIVE, 480, visible lines.
- V_TOTAL, 525, lines per frame.
- ADDR_W, 15, RAM word address width.
- Derived, not overridable: WPL = H_ACTIVE/8 = 80 words per framebuffer line; FB_WORDS = (V_ACTIVE/2)*WPL = 19200.

Ports:
- clk, in, 1, pixel clock (25 MHz domain of the sync generator).
- rst, in, 1, synchronous active-high reset.
- pixel_x, in, 10, current raster column, 0..H_TOTAL-1.
- pixel_y, in, 10, current raster line, 0..V_TOTAL-1.
- pix_color, out, 4, framebuffer colour index for the raster position.
- pix_blank, out, 1, 1 outside the active area.
- host_req, in, 1, host transaction request; held with address/data stable until host_ack.
- host_addr, in, ADDR_W, host word address.
- host_wdata, in, 16, host write data.
- host_ack, out, 1, one-cycle pulse when the transaction reaches the RAM.
- mem_addr, out, ADDR_W, RAM address (registered).
- mem_we, out, 1, RAM write enable (registered).
- mem_wdata, out, 16, RAM write data (registered).
- mem_rdata, in, 16, RAM read data, valid the cycle after mem_addr.

Behaviour:
- Reset: all outputs 0 except pix_blank=1. Word buffers cur_word/next_word = 0. Line base = 0. Arbitration state cleared. Reset mid-frame abandons any pending fetch/grant with no ack. Display shows colour 0 until the first fetches after reset complete.
- Slot decision: made in cycle t from that cycle's pixel_x/pixel_y; drives mem_* and host_ack in t+1. mem_rdata for a read decided at t is sampled at t+2.
- Display slots: x in {0, 8, ..., 8*(WPL-1)-8} on lines y < V_ACTIVE; this fetches group g+1 = x/8+1 of line y.
- Line-start slot: x = H_TOTAL-8 (792) on line y. It fetches group 0 of the next line (y+1, or line 0 when y = V_TOTAL-1), only if that line is active.
- Fetch address: (target_y>>1)*WPL + g. The line base is kept incrementally (+WPL after every odd active line, reset to 0 at frame wrap); no multiplier.
- Captured word goes to next_word. next_word moves to cur_word when pixel_x[2:0]==0 in the active area.
- Pixel output: pix_color(t+1) = nibble pixel_x[2:1] of the word covering (pixel_x, pixel_y) at t. pix_blank(t+1) = (x >= H_ACTIVE or y >= V_ACTIVE) at t. pix_color is forced to 0 while blanked.
- Host grant rule: grant at t iff host_req, t is not a display/line-start slot, and host_ack is not being driven at t (no back-to-back grants). Maximum host rate is one per 2 cycles.
- Granted write: mem_we=1, mem_addr=host_addr, mem_wdata=host_wdata in t+1; host_ack=1 in t+1.
- Out of range: host_addr >= FB_WORDS is acked but mem_we stays 0 (dropped).
- Idle cycles: mem_we=0 and mem_addr holds its last value.
- Host starvation bound: during active display the host waits at most 2 cycles. In blanking it is never blocked except at x=792.

Optional Feature:
- Macro: VRAM_HOST_READ_EN.
- Defined:
  - Adds host_we (in, 1), host_rdata (out, 16) and host_rvalid (out, 1).
  - Requests with host_we=0 are reads, granted under the same rules.
  - host_rvalid pulses in the cycle after host_ack, with host_rdata = mem_rdata; out-of-range reads return 0.
  - host_rdata holds its value between pulses.
  - Reset clears host_rdata and host_rvalid.
- Undefined: those three ports do not exist and every host request is a write.

Test Plan:
- Reset held 3 cycles mid-line at x=300, y=100, then released -> pix_color=0, pix_blank=1, mem_we=0, host_ack=0 during reset; first line-start fetch issues at x=792.
- RAM preloaded word[i] = i; run lines y=0..3 -> at x=8..15 of y=0 and y=1, pix_color = nibbles of 0x0001 in order 1,1,0,0,0,0,0,0; on y=2, words start at 80 (0x0050).
- Fetch timing: at y=0, mem_addr=1 one cycle after x=0 and mem_addr=79 one cycle after x=624; at y=524, mem_addr=0 one cycle after x=792.
- Host holds host_req=1 with addr=0x0100, data=0xABCD, presented at x=8 -> no grant while x=8; ack with mem_we=1 at x=10; word 0x0100 reads back 0xABCD. Continuous requests give acks spaced at least 2 cycles apart.
- Host write to addr 19200 -> host_ack pulses, mem_we stays 0, RAM unchanged.
- With VRAM_HOST_READ_EN defined: read request to addr 5 during vertical blank -> host_ack at t+1, host_rvalid at t+2 with host_rdata=0x0005.
